// File: rtl/usf_pkg.sv
// usf_pkg: shared defaults, sample/channel types and modulo helpers for USF recovery
//   cmod(x, l)    : ((x + 2^l) mod 2^(l+1)) - 2^l, i.e. sign-extension of x[l:0]
//   round2l(x, l) : nearest multiple of 2^(l+1) to x, so x - round2l(x) == cmod(x)
package usf_pkg;
  localparam int DEF_ADC_RES = 12;
  localparam int DEF_OUT_RES = 24;
  localparam int DEF_ORDER = 3;
  localparam int DEF_LAMBDA_LOG2 = 10;
  localparam int DEF_CH = 4;
  localparam int DEF_CH_W = (DEF_CH > 1) ? $clog2(DEF_CH) : 1;
  typedef logic signed [DEF_OUT_RES-1:0] sample_t;
  typedef logic [DEF_CH_W-1:0] ch_t;
  typedef logic signed [63:0] wide_t;
  function automatic wide_t cmod(input wide_t x, input int lam_log2);
    wide_t m;
    wide_t r;
    m = (wide_t'(1) << (lam_log2 + 1)) - wide_t'(1);
    r = x & m;
    return r[lam_log2[5:0]] ? r - m - wide_t'(1) : r;
  endfunction
  function automatic wide_t round2l(input wide_t x, input int lam_log2);
    return x - cmod(x, lam_log2);
  endfunction
endpackage

// File: rtl/usf_channel_state.sv
// usf_channel_state: per-channel h/e/w register file, one read port, one write port
//   i_clr            : zero every entry (wins over a write)
//   i_rd_ch -> o_h/o_e/o_w : read, forwarded from the write port on a same-channel write
//   i_we, i_wr_ch, i_h/i_e/i_w : commit of one channel's history, integrators and warm count
module usf_channel_state #(
  parameter int CH = 4,
  parameter int ORDER = 3,
  parameter int OUT_RES = 24,
  parameter int CH_W = 2,
  parameter int W_W = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clr,
  input  logic [CH_W-1:0]                 i_rd_ch,
  output logic [ORDER-1:0][OUT_RES-1:0]   o_h,
  output logic [ORDER-1:0][OUT_RES-1:0]   o_e,
  output logic [W_W-1:0]                  o_w,
  input  logic                            i_we,
  input  logic [CH_W-1:0]                 i_wr_ch,
  input  logic [ORDER-1:0][OUT_RES-1:0]   i_h,
  input  logic [ORDER-1:0][OUT_RES-1:0]   i_e,
  input  logic [W_W-1:0]                  i_w
);
  logic [CH-1:0][ORDER-1:0][OUT_RES-1:0] r_h;
  logic [CH-1:0][ORDER-1:0][OUT_RES-1:0] r_e;
  logic [CH-1:0][W_W-1:0] r_w;
  logic w_fwd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_e <= '0;
      r_w <= '0;
    end else if (i_clr) begin
      r_h <= '0;
      r_e <= '0;
      r_w <= '0;
    end else if (i_we) begin
      r_h[i_wr_ch] <= i_h;
      r_e[i_wr_ch] <= i_e;
      r_w[i_wr_ch] <= i_w;
    end
  end
  // a write landing this cycle is what the reader must see next cycle
  assign w_fwd = i_we && (i_wr_ch == i_rd_ch);
  assign o_h = w_fwd ? i_h : r_h[i_rd_ch];
  assign o_e = w_fwd ? i_e : r_e[i_rd_ch];
  assign o_w = w_fwd ? i_w : r_w[i_rd_ch];
endmodule

// File: rtl/usf_recovery_stream.sv
// usf_recovery_stream: streaming multi-channel unlimited-sampling recovery engine
//   i_in_valid/o_in_ready/i_in_data/i_in_ch : folded sample input (tags >= CH are dropped)
//   i_bypass : pass the raw sample through untouched; i_flush : zero all channel state
//   o_out_valid/i_out_ready/o_out_data/o_out_ch/o_out_settled : recovered sample output
//   Pipeline S1 (difference + residual) -> S2 (integrate + commit) -> output register.
module usf_recovery_stream import usf_pkg::*; #(
  parameter int ADC_RES = DEF_ADC_RES,
  parameter int OUT_RES = DEF_OUT_RES,
  parameter int ORDER = DEF_ORDER,
  parameter int LAMBDA_LOG2 = DEF_LAMBDA_LOG2,
  parameter int CH = DEF_CH,
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [ADC_RES-1:0] i_in_data,
  input  logic [CH_W-1:0]    i_in_ch,
  input  logic               i_bypass,
  input  logic               i_flush,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [OUT_RES-1:0] o_out_data,
  output logic [CH_W-1:0]    o_out_ch,
  output logic               o_out_settled
);
  localparam int W_W = $clog2(ORDER + 1);
  logic w_adv, w_keep, w_we, w_set;
  logic [W_W-1:0] w_w, w_w_nx;
  logic [ORDER-1:0][OUT_RES-1:0] w_h, w_e, w_s;
  logic [ORDER:0][OUT_RES-1:0] w_d;
  logic [OUT_RES-1:0] w_res;
  logic r_s1_v, r_s1_byp, r_s1_cm;
  logic [OUT_RES-1:0] r_s1_y;
  logic [CH_W-1:0] r_s1_ch;
  logic r_s2_v, r_s2_byp, r_s2_cm, r_s2_set;
  logic [OUT_RES-1:0] r_s2_y, r_s2_res;
  logic [CH_W-1:0] r_s2_ch;
  logic [ORDER-1:0][OUT_RES-1:0] r_s2_h, r_s2_e;
  logic [W_W-1:0] r_s2_w;
  assign w_adv = !o_out_valid || i_out_ready;
  assign o_in_ready = w_adv && !i_flush;
  // zero-extended compare keeps the range test honest when CH is a power of two
  assign w_keep = i_in_valid && o_in_ready && ({1'b0, i_in_ch} < (CH_W + 1)'(CH));
  // r_*_cm: the beat may still commit state; cleared by a flush it shares the pipe with
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1_cm <= 1'b0;
      r_s1_byp <= 1'b0;
      r_s1_y <= '0;
      r_s1_ch <= '0;
    end else if (w_adv) begin
      r_s1_v <= w_keep;
      r_s1_cm <= 1'b1;
      if (w_keep) begin
        r_s1_byp <= i_bypass;
        r_s1_y <= {{(OUT_RES - ADC_RES){i_in_data[ADC_RES-1]}}, i_in_data};
        r_s1_ch <= i_in_ch;
      end
    end else if (i_flush) begin
      r_s1_cm <= 1'b0;
    end
  end
  usf_channel_state #(
    .CH(CH), .ORDER(ORDER), .OUT_RES(OUT_RES), .CH_W(CH_W), .W_W(W_W)
  ) u_state (
    .clk(clk), .rst_n(rst_n), .i_clr(i_flush),
    .i_rd_ch(r_s1_ch), .o_h(w_h), .o_e(w_e), .o_w(w_w),
    .i_we(w_we), .i_wr_ch(r_s2_ch), .i_h(r_s2_h), .i_e(w_s), .i_w(r_s2_w)
  );
  always_comb begin
    w_d[0] = r_s1_y;
    for (int k = 1; k <= ORDER; k++) w_d[k] = w_d[k-1] - w_h[k-1];
  end
  // residual cmod(D) - D is minus the nearest multiple of 2*lambda
  assign w_res = OUT_RES'(-round2l(wide_t'(signed'(w_d[ORDER])), LAMBDA_LOG2));
  assign w_set = (w_w == W_W'(ORDER));
  assign w_w_nx = w_set ? w_w : w_w + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_s2_cm <= 1'b0;
      r_s2_byp <= 1'b0;
      r_s2_set <= 1'b0;
      r_s2_y <= '0;
      r_s2_res <= '0;
      r_s2_ch <= '0;
      r_s2_h <= '0;
      r_s2_e <= '0;
      r_s2_w <= '0;
    end else if (w_adv) begin
      r_s2_v <= r_s1_v;
      r_s2_cm <= r_s1_cm && !i_flush;
      if (r_s1_v) begin
        r_s2_byp <= r_s1_byp;
        r_s2_set <= w_set;
        r_s2_y <= r_s1_y;
        r_s2_res <= w_res;
        r_s2_ch <= r_s1_ch;
        r_s2_h <= w_d[ORDER-1:0];
        r_s2_e <= w_e;
        r_s2_w <= w_w_nx;
      end
    end else if (i_flush) begin
      r_s2_cm <= 1'b0;
    end
  end
  always_comb begin
    w_s[ORDER-1] = r_s2_e[ORDER-1] + r_s2_res;
    for (int k = ORDER - 2; k >= 0; k--) w_s[k] = r_s2_e[k] + w_s[k+1];
  end
  assign w_we = w_adv && r_s2_v && !r_s2_byp && r_s2_cm;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_out_data <= '0;
      o_out_ch <= '0;
      o_out_settled <= 1'b0;
    end else if (w_adv) begin
      o_out_valid <= r_s2_v;
      if (r_s2_v) begin
        o_out_data <= r_s2_byp ? r_s2_y : r_s2_y + w_s[0];
        o_out_ch <= r_s2_ch;
        o_out_settled <= r_s2_byp || r_s2_set;
      end
    end
  end
endmodule

// File: tb/tb_usf_recovery_stream.sv
// tb_usf_recovery_stream: directed vector bench, ORDER=2, lambda=64, CH=5
module tb_usf_recovery_stream;
  localparam int ADC_RES = 12;
  localparam int OUT_RES = 24;
  localparam int ORDER = 2;
  localparam int LL2 = 6;
  localparam int CH = 5;
  localparam int CH_W = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic i_in_valid, o_in_ready, i_bypass, i_flush, o_out_valid, i_out_ready, o_out_settled;
  logic [ADC_RES-1:0] i_in_data;
  logic [CH_W-1:0] i_in_ch, o_out_ch;
  logic [OUT_RES-1:0] o_out_data;
  typedef struct {int ch; bit byp; int din; int exp; bit set; bit out;} vec_t;
  typedef struct {int ch; int data; bit set;} exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  usf_recovery_stream #(
    .ADC_RES(ADC_RES), .OUT_RES(OUT_RES), .ORDER(ORDER), .LAMBDA_LOG2(LL2), .CH(CH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .i_in_ch(i_in_ch), .i_bypass(i_bypass), .i_flush(i_flush),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_ch(o_out_ch), .o_out_settled(o_out_settled)
  );
  function automatic vec_t mk(input int ch, input bit byp, input int din, input int exp, input bit set, input bit out);
    vec_t v;
    v.ch = ch;
    v.byp = byp;
    v.din = din;
    v.exp = exp;
    v.set = set;
    v.out = out;
    return v;
  endfunction
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  // every visible output beat is compared to the head of the expectation queue, also while stalled
  always @(negedge clk) begin
    if (rst_n && o_out_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected actual data=%0d ch=%0d required no output", $signed(o_out_data), o_out_ch);
      end else begin
        if (o_out_data !== 24'(q[0].data) || o_out_ch !== 3'(q[0].ch) || o_out_settled !== q[0].set) begin
          failures++;
          $display("FAIL out_beat actual data=%0d ch=%0d settled=%0b required data=%0d ch=%0d settled=%0b",
                   $signed(o_out_data), o_out_ch, o_out_settled, q[0].data, q[0].ch, q[0].set);
        end
        if (i_out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic send(input vec_t v);
    int n = 0;
    exp_t e;
    i_in_valid = 1'b1;
    i_in_ch = 3'(v.ch);
    i_bypass = v.byp;
    i_in_data = 12'(v.din);
    @(negedge clk);
    while (!o_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!o_in_ready) begin
      failures++;
      $display("FAIL accept_timeout actual in_ready=0 required in_ready=1 ch=%0d", v.ch);
    end else if (v.out) begin
      e.ch = v.ch;
      e.data = v.exp;
      e.set = v.set;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_bypass = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t va[$], vb[$], vc[$], vd[$], ve[$];
    va = '{mk(0,0,0,0,0,1), mk(0,0,10,10,0,1), mk(0,0,40,40,1,1),
           mk(0,0,-38,90,1,1), mk(0,0,32,160,1,1), mk(0,0,-6,250,1,1)};
    vb = '{mk(0,0,0,0,0,1), mk(1,0,10,10,0,1), mk(2,0,-20,-20,0,1), mk(3,0,50,50,0,1),
           mk(0,0,30,30,0,1), mk(1,0,-30,-30,0,1), mk(2,0,5,5,0,1), mk(3,0,-18,110,0,1),
           mk(0,0,60,60,1,1), mk(1,0,58,-70,1,1), mk(2,0,30,30,1,1), mk(3,0,42,170,1,1),
           mk(5,0,33,0,0,0),
           mk(0,0,-38,90,1,1), mk(1,0,18,-110,1,1), mk(2,0,55,55,1,1), mk(3,0,-26,230,1,1),
           mk(0,0,-8,120,1,1), mk(1,0,-22,-150,1,1), mk(2,0,-48,80,1,1), mk(3,0,34,290,1,1)};
    vc = '{mk(0,0,0,0,0,1), mk(0,0,30,30,0,1), mk(0,0,60,60,1,1), mk(0,1,700,700,1,1),
           mk(0,0,-38,90,1,1), mk(0,1,-1000,-1000,1,1), mk(0,0,-8,120,1,1),
           mk(2,0,-20,-20,0,1), mk(2,0,5,5,0,1), mk(2,0,30,30,1,1), mk(2,0,55,55,1,1),
           mk(2,0,-48,80,1,1), mk(2,0,-23,105,1,1), mk(2,0,2,130,1,1), mk(2,0,27,155,1,1),
           mk(2,0,52,180,1,1), mk(2,0,-51,205,1,1)};
    vd = '{mk(2,0,7,7,0,1), mk(2,0,17,17,0,1), mk(2,0,27,27,1,1)};
    ve = '{mk(0,0,0,0,0,1), mk(0,0,30,30,0,1), mk(0,0,60,60,1,1), mk(0,0,-38,90,1,1)};
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_in_ch = '0;
    i_bypass = 1'b0;
    i_flush = 1'b0;
    i_out_ready = 1'b1;
    #1;
    check("rst_out_valid", int'(o_out_valid), 0);
    check("rst_out_data", int'(o_out_data), 0);
    check("rst_out_ch", int'(o_out_ch), 0);
    check("rst_out_settled", int'(o_out_settled), 0);
    check("rst_in_ready", int'(o_in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (va[i]) send(va[i]);
    drain();
    do_reset();
    fork
      foreach (vb[i]) send(vb[i]);
      begin
        repeat (8) @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", int'(o_in_ready), 0);
        repeat (5) @(posedge clk);
        #1;
        i_out_ready = 1'b1;
      end
    join
    drain();
    do_reset();
    foreach (vc[i]) send(vc[i]);
    drain();
    i_flush = 1'b1;
    i_in_valid = 1'b1;
    i_in_ch = 3'd2;
    i_in_data = 12'd99;
    @(negedge clk);
    check("flush_in_ready", int'(o_in_ready), 0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_in_valid = 1'b0;
    foreach (vd[i]) send(vd[i]);
    drain();
    do_reset();
    foreach (ve[i]) send(ve[i]);
    check("pre_reset_valid", int'(o_out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(o_out_valid), 0);
    check("async_reset_data", int'(o_out_data), 0);
    q.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mk(0,0,5,5,0,1));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
